// File: rtl/dyn_configurator_pkg.sv
// mdc_cfg_pkg: FSM state encodings and ID/index helpers shared by
// dyn_configurator and its configuration table.
package mdc_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2
    } cfg_state_e;

    localparam int ID_NONE = 0;

    // Configuration IDs are 1-based; ID_NONE marks "nothing applied".
    function automatic logic id_valid(input int unsigned id, input int unsigned n_cfg);
        return (id != ID_NONE) && (id <= n_cfg);
    endfunction

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned n_cfg);
        return idx < n_cfg;
    endfunction

endpackage

// File: rtl/dyn_configurator_cfg_table.sv
// cfg_table: select-pattern table with an asynchronous read port. With
// CFG_TABLE_WR_EN defined it is a writable register array, else constant.
module cfg_table
    import mdc_cfg_pkg::*;
#(
    parameter int                       SEL_W    = 4,
    parameter int                       N_CFG    = 2,
    parameter logic [N_CFG*SEL_W-1:0]   SEL_INIT = '0,
    parameter int                       ADDR_W   = 1
) (
`ifdef CFG_TABLE_WR_EN
    input  logic              clock,
    input  logic              reset,
    input  logic              tbl_we,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [SEL_W-1:0]  tbl_data,
`endif
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [SEL_W-1:0]  rd_data
);

    logic [SEL_W-1:0] tbl [N_CFG];

`ifdef CFG_TABLE_WR_EN
    // Out-of-range write addresses are dropped rather than aliased.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CFG; k++) begin
                tbl[k] <= SEL_INIT[k*SEL_W +: SEL_W];
            end
        end else if (tbl_we && idx_in_range(32'(tbl_addr), N_CFG)) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end
`else
    for (genvar k = 0; k < N_CFG; k++) begin : g_const
        assign tbl[k] = SEL_INIT[k*SEL_W +: SEL_W];
    end
`endif

    always_comb begin
        rd_data = '0;
        if (idx_in_range(32'(rd_addr), N_CFG)) begin
            rd_data = tbl[rd_addr];
        end
    end

endmodule

// File: rtl/dyn_configurator.sv
// dyn_configurator: switches datapath select lines between table-held
// configurations once the datapath drains. Optional macro: CFG_TABLE_WR_EN.
module dyn_configurator
    import mdc_cfg_pkg::*;
#(
    parameter int                     ID_W       = 8,
    parameter int                     SEL_W      = 4,
    parameter int                     N_CFG      = 2,
    parameter logic [N_CFG*SEL_W-1:0] SEL_INIT   = {4'b1111, 4'b0000},
    parameter int                     SETTLE_CYC = 2,
    localparam int                    ADDR_W     = (N_CFG > 1) ? $clog2(N_CFG) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ID_W-1:0]   req_id,
    output logic              req_ready,
    input  logic              dp_idle,
`ifdef CFG_TABLE_WR_EN
    input  logic              tbl_we,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [SEL_W-1:0]  tbl_data,
`endif
    output logic [SEL_W-1:0]  sel,
    output logic [ID_W-1:0]   active_id,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    cfg_state_e       state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [SEL_W-1:0] pend_q, pend_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [ID_W-1:0]  act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [ADDR_W-1:0] rd_addr;
    logic [SEL_W-1:0]  rd_data;
    logic              accept;
    logic              req_ok;

    // IDs are 1-based; an invalid ID may alias a real entry but is never used.
    assign rd_addr = ADDR_W'(req_id - ID_W'(1));
    assign accept  = req_valid && (state_q == ST_IDLE);
    assign req_ok  = id_valid(32'(req_id), N_CFG);

    cfg_table #(
        .SEL_W    (SEL_W),
        .N_CFG    (N_CFG),
        .SEL_INIT (SEL_INIT),
        .ADDR_W   (ADDR_W)
    ) u_table (
`ifdef CFG_TABLE_WR_EN
        .clock    (clock),
        .reset    (reset),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
`endif
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d = req_id;
                    if (!req_ok) begin
                        err_d = 1'b1;
                    end else if (req_id == act_q) begin
                        done_d = 1'b1;
                    end else begin
                        // Snapshot now so later table writes cannot leak in.
                        pend_d  = rd_data;
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (dp_idle) begin
                    sel_d = pend_q;
                    act_d = id_q;
                    cnt_d = '0;
                    if (SETTLE_CYC == 0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            id_q    <= ID_W'(ID_NONE);
            pend_q  <= '0;
            sel_q   <= '0;
            act_q   <= ID_W'(ID_NONE);
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign cfg_busy  = (state_q == ST_DRAIN) || (state_q == ST_SETTLE);
    assign sel       = sel_q;
    assign active_id = act_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_dyn_configurator.sv
// Self-checking bench for dyn_configurator: directed scenarios plus a
// randomized request stream checked against a transaction-level model.
module tb_dyn_configurator;

    localparam int         ID_W       = 8;
    localparam int         SEL_W      = 4;
    localparam int         N_CFG      = 2;
    localparam int         SETTLE_CYC = 2;
    localparam int         ADDR_W     = 1;
    localparam logic [7:0] INIT_TBL   = {4'b1111, 4'b0000};

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic [ID_W-1:0]   req_id = '0;
    logic              req_ready;
    logic              dp_idle = 1'b0;
    logic [SEL_W-1:0]  sel;
    logic [ID_W-1:0]   active_id;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;
`ifdef CFG_TABLE_WR_EN
    logic              tbl_we = 1'b0;
    logic [ADDR_W-1:0] tbl_addr = '0;
    logic [SEL_W-1:0]  tbl_data = '0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: what the configurator should have applied.
    logic [SEL_W-1:0] ref_tbl [N_CFG];
    logic [SEL_W-1:0] ref_sel;
    int               ref_act;

    dyn_configurator #(
        .ID_W       (ID_W),
        .SEL_W      (SEL_W),
        .N_CFG      (N_CFG),
        .SEL_INIT   (INIT_TBL),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_id    (req_id),
        .req_ready (req_ready),
        .dp_idle   (dp_idle),
`ifdef CFG_TABLE_WR_EN
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
`endif
        .sel       (sel),
        .active_id (active_id),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        logic [7:0] init;
        init = INIT_TBL;
        for (int k = 0; k < N_CFG; k++) ref_tbl[k] = init[k*SEL_W +: SEL_W];
        ref_sel = '0;
        ref_act = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"},   32'(sel), 32'(0));
        chk({tag, "_act"},   32'(active_id), 32'(0));
        chk({tag, "_busy"},  32'(cfg_busy), 32'(0));
        chk({tag, "_done"},  32'(cfg_done), 32'(0));
        chk({tag, "_err"},   32'(cfg_err), 32'(0));
        chk({tag, "_ready"}, 32'(req_ready), 32'(1));
    endtask

    // One complete request transaction; optional table write on the accept edge.
    task automatic do_req(input int id, input int delay, input bit we, input int waddr,
                          input logic [SEL_W-1:0] wdata);
        logic [SEL_W-1:0] old_sel, new_sel;
        int               old_act;
        bit               valid;
        old_sel = ref_sel;
        old_act = ref_act;
        valid   = (id >= 1) && (id <= N_CFG);
        new_sel = valid ? ref_tbl[id-1] : '0;
        chk("ready_pre", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_id    = ID_W'(id);
        dp_idle   = (delay == 0);
`ifdef CFG_TABLE_WR_EN
        tbl_we   = we;
        tbl_addr = ADDR_W'(waddr);
        tbl_data = wdata;
`endif
        @(negedge clock);
        req_valid = 1'b0;
`ifdef CFG_TABLE_WR_EN
        tbl_we = 1'b0;
        if (we && waddr < N_CFG) ref_tbl[waddr] = wdata;
`endif
        if (!valid) begin
            chk("inv_err",  32'(cfg_err), 32'(1));
            chk("inv_done", 32'(cfg_done), 32'(0));
            chk("inv_busy", 32'(cfg_busy), 32'(0));
            chk("inv_sel",  32'(sel), 32'(old_sel));
            chk("inv_act",  32'(active_id), 32'(old_act));
        end else if (id == old_act) begin
            chk("same_done", 32'(cfg_done), 32'(1));
            chk("same_err",  32'(cfg_err), 32'(0));
            chk("same_busy", 32'(cfg_busy), 32'(0));
            chk("same_sel",  32'(sel), 32'(old_sel));
        end else begin
            chk("sw_err",  32'(cfg_err), 32'(0));
            chk("sw_done", 32'(cfg_done), 32'(0));
            for (int i = 0; i < delay; i++) begin
                chk("drain_busy",  32'(cfg_busy), 32'(1));
                chk("drain_ready", 32'(req_ready), 32'(0));
                chk("drain_sel",   32'(sel), 32'(old_sel));
                @(negedge clock);
            end
            dp_idle = 1'b1;
            chk("drain_busy",  32'(cfg_busy), 32'(1));
            chk("drain_sel",   32'(sel), 32'(old_sel));
            @(negedge clock);
            ref_sel = new_sel;
            ref_act = id;
            chk("sw_sel", 32'(sel), 32'(ref_sel));
            chk("sw_act", 32'(active_id), 32'(ref_act));
            for (int j = 0; j < SETTLE_CYC; j++) begin
                chk("settle_busy", 32'(cfg_busy), 32'(1));
                chk("settle_done", 32'(cfg_done), 32'(0));
                chk("settle_sel",  32'(sel), 32'(ref_sel));
                @(negedge clock);
            end
            chk("fin_done",  32'(cfg_done), 32'(1));
            chk("fin_busy",  32'(cfg_busy), 32'(0));
            chk("fin_ready", 32'(req_ready), 32'(1));
            chk("fin_err",   32'(cfg_err), 32'(0));
        end
        dp_idle = 1'($urandom_range(0, 1));
        @(negedge clock);
        chk("post_done", 32'(cfg_done), 32'(0));
        chk("post_err",  32'(cfg_err), 32'(0));
        chk("post_sel",  32'(sel), 32'(ref_sel));
        chk("post_act",  32'(active_id), 32'(ref_act));
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        chk_reset_outputs("rst_hold");
        reset = 1'b0;
        @(negedge clock);
        chk_reset_outputs("rst_rel");

        // Basic switch to ID 1 and latency with dp_idle high.
        do_req(1, 0, 1'b0, 0, '0);
        // Long drain towards ID 2.
        do_req(2, 5, 1'b0, 0, '0);
        // Invalid IDs.
        do_req(0, 0, 1'b0, 0, '0);
        do_req(9, 0, 1'b0, 0, '0);
        // Re-request of the active ID.
        do_req(2, 0, 1'b0, 0, '0);

`ifdef CFG_TABLE_WR_EN
        do_req(1, 0, 1'b0, 0, '0);
        do_req(2, 0, 1'b1, 1, 4'b1010);
        do_req(1, 0, 1'b0, 0, '0);
        do_req(2, 0, 1'b0, 0, '0);
`endif

        for (int n = 0; n < 40; n++) begin
            int id;
            id = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 12));
            do_req(id, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        // Reset in SETTLE, with a modified table entry that must be restored.
        if (ref_act != 1) do_req(1, 0, 1'b0, 0, '0);
`ifdef CFG_TABLE_WR_EN
        tbl_we = 1'b1; tbl_addr = 1'b1; tbl_data = 4'b0101;
        @(negedge clock);
        tbl_we = 1'b0;
        ref_tbl[1] = 4'b0101;
`endif
        req_valid = 1'b1; req_id = 8'd2; dp_idle = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        chk("pre_rst_busy", 32'(cfg_busy), 32'(1));
        #2 reset = 1'b1;
        #1 chk_reset_outputs("rst_settle");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        chk_reset_outputs("rst_after");
        do_req(2, 0, 1'b0, 0, '0);
        chk("restored_sel", 32'(sel), 32'(4'b1111));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Failsafe in case the stimulus flow ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dyn_configurator.md
DYN_CONFIGURATOR -- requirements
Module: dyn_configurator

Interface
REQ-001 Parameter ID_W, default 8, width of configuration ID.
REQ-002 Parameter SEL_W, default 4, number of datapath select lines.
REQ-003 Parameter N_CFG, default 2, number of configurations; valid IDs 1..N_CFG.
REQ-004 Parameter SEL_INIT, default {4'b1111,4'b0000}, packed N_CFG*SEL_W reset table contents; entry k (ID k+1) is bits [k*SEL_W +: SEL_W].
REQ-005 Parameter SETTLE_CYC, default 2, post-switch settle cycles (0 allowed).
REQ-006 clock  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 req_valid  in  1  reconfiguration request valid.
REQ-009 req_id  in  ID_W  requested configuration ID.
REQ-010 req_ready  out  1  high only in IDLE.
REQ-011 dp_idle  in  1  datapath drained; switch is permitted.
REQ-012 sel  out  SEL_W  registered select lines to the datapath switch boxes.
REQ-013 active_id  out  ID_W  ID currently applied; 0 = none.
REQ-014 cfg_busy  out  1  high in DRAIN and SETTLE.
REQ-015 cfg_done  out  1  one-cycle pulse on completion.
REQ-016 cfg_err  out  1  one-cycle pulse on an invalid ID.
REQ-017 tbl_we / tbl_addr (clog2(N_CFG)) / tbl_data (SEL_W)  in  table write port, present only with CFG_TABLE_WR_EN.

Function
REQ-018 FSM states: IDLE, DRAIN, SETTLE; reset state IDLE.
REQ-019 Accept on edge with req_valid && req_ready; req_id is latched and its table entry snapshotted into pending_sel on that edge.
REQ-020 Invalid accepted ID (0 or >N_CFG): stay IDLE, sel/active_id unchanged, cfg_err high the next cycle.
REQ-021 Valid ID equal to active_id: stay IDLE, no drain, cfg_done high the next cycle.
REQ-022 Other valid ID: go to DRAIN; cfg_busy high from the next cycle.
REQ-023 DRAIN: on first edge with dp_idle=1, sel<=pending_sel, active_id<=latched ID; go to SETTLE, or to IDLE if SETTLE_CYC=0.
REQ-024 SETTLE: counter counts SETTLE_CYC edges, then goes to IDLE.
REQ-025 cfg_done is high for exactly the one cycle after entry to IDLE from DRAIN/SETTLE.
REQ-026 sel changes only in DRAIN->next transition; never glitches in IDLE or SETTLE.
REQ-027 Latency with dp_idle held high, SETTLE_CYC=2: accept edge 0, sel updates edge 1, cfg_done high after edge 3, req_ready high after edge 3.
REQ-028 cfg_done and cfg_err are never high in the same cycle.

Reset
REQ-029 Reset asserted at any time, including mid-DRAIN/SETTLE: state=IDLE, sel=0, active_id=0, cfg_busy=0, cfg_done=0, cfg_err=0, counter=0, table=SEL_INIT.
REQ-030 req_ready is high in the first cycle after reset deassertion.

Configuration
REQ-031 Macro CFG_TABLE_WR_EN defined: table is a register array. tbl_we writes tbl_data to entry tbl_addr on the edge. tbl_addr>=N_CFG is ignored.
REQ-032 A write never alters pending_sel or the applied sel. A new entry takes effect only on a later request.
REQ-033 Write and accept of the same entry on the same edge: the snapshot takes the old value.
REQ-034 Macro undefined: write ports absent and the table is the constant SEL_INIT.

Structure
REQ-035 Shared package mdc_cfg_pkg holds the FSM state encodings, the ID_NONE=0 constant, and the helper function id_valid(id, N_CFG).
REQ-036 The table is a single sub-module cfg_table: async read port, optional write port.

Verification
REQ-037 After reset, req_id=1, dp_idle=1 -> sel=4'b0000 at edge 1, active_id=1, cfg_done pulse after edge 3.
REQ-038 active_id=1, req_id=2, dp_idle held low for 5 cycles -> cfg_busy high and sel=0000 throughout. After dp_idle rises, sel=1111 at the next edge.
REQ-039 req_id=0, then req_id=9 -> cfg_err pulse each time, sel/active_id unchanged, no cfg_busy.
REQ-040 active_id=2, req_id=2 -> cfg_done the next cycle, cfg_busy never high.
REQ-041 CFG_TABLE_WR_EN: write entry 1 = 4'b1010 on the accept edge of req_id=2 -> sel=1111. A later request sequence 1 then 2 -> sel=1010.
REQ-042 Reset pulsed during SETTLE -> all outputs at reset values, table restored to SEL_INIT, req_ready high after deassertion.
